// File: rtl/sp_reg_file.sv
// Scratchpad register file (A,B,C,D,E,H,L) with a registered read port, INr/DCr with
// Z/S/P flags, and the H:L address. Optional macro SP_SEL_CHECK_EN rejects multi-hot selects.
module sp_reg_cell #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module sp_reg_file #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 7,
  parameter int HL_ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REGS-1:0]  rd_sel,
  input  logic [NUM_REGS-1:0]  wr_sel,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 incdec,
  input  logic                 dec,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic [HL_ADDR_W-1:0] hl_addr,
  output logic                 flag_z,
  output logic                 flag_s,
  output logic                 flag_p,
  output logic                 flags_valid,
  output logic                 sel_err
);
  localparam int IDX_H = 5;
  localparam int IDX_L = 6;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0] rd_oh, wr_oh;
  logic [DATA_W-1:0]   cur_wr, cur_rd, rmw, new_val, rd_next;
  logic                wr_en, rd_en, bypass;

`ifdef SP_SEL_CHECK_EN
  logic rd_multi, wr_multi;
  // x & (x-1) clears the lowest set bit; anything left means more than one bit set
  assign rd_multi = (rd_sel & (rd_sel - NUM_REGS'(1))) != '0;
  assign wr_multi = (wr_sel & (wr_sel - NUM_REGS'(1))) != '0;
  assign rd_oh    = rd_multi ? '0 : rd_sel;
  assign wr_oh    = wr_multi ? '0 : wr_sel;
`else
  // x & -x isolates the lowest set bit, giving lowest-index priority
  assign rd_oh = rd_sel & (~rd_sel + NUM_REGS'(1));
  assign wr_oh = wr_sel & (~wr_sel + NUM_REGS'(1));
`endif

  always_comb begin
    cur_wr = '0;
    cur_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_oh[i]) cur_wr = cur_wr | regs[i];
      if (rd_oh[i]) cur_rd = cur_rd | regs[i];
    end
    rmw     = dec ? cur_wr - DATA_W'(1) : cur_wr + DATA_W'(1);
    new_val = incdec ? rmw : wr_data;
    wr_en   = |wr_oh;
    rd_en   = |rd_oh;
    bypass  = |(rd_oh & wr_oh);
    rd_next = bypass ? new_val : cur_rd;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    sp_reg_cell #(.DATA_W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_oh[g]),
      .d     (new_val),
      .q     (regs[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
`ifdef SP_SEL_CHECK_EN
      else if (rd_multi) rd_data <= '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z      <= 1'b0;
      flag_s      <= 1'b0;
      flag_p      <= 1'b0;
      flags_valid <= 1'b0;
    end else begin
      flags_valid <= wr_en & incdec;
      if (wr_en && incdec) begin
        flag_z <= (new_val == '0);
        flag_s <= new_val[DATA_W-1];
        flag_p <= ~^new_val;
      end
    end
  end

`ifdef SP_SEL_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= rd_multi | wr_multi;
  end
`else
  assign sel_err = 1'b0;
`endif

  assign hl_addr = {regs[IDX_H][HL_ADDR_W-DATA_W-1:0], regs[IDX_L]};
endmodule

// File: tb/tb_sp_reg_file.sv
// Scoreboard bench for sp_reg_file: a register model predicts reads and flags, which are
// queued at drive time and popped when rd_valid / flags_valid pulse.
module tb_sp_reg_file;
  logic        clk, rst_n;
  logic [6:0]  rd_sel, wr_sel;
  logic [7:0]  wr_data;
  logic        incdec, dec;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [13:0] hl_addr;
  logic        flag_z, flag_s, flag_p, flags_valid, sel_err;

  sp_reg_file dut (
    .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel), .wr_sel(wr_sel), .wr_data(wr_data),
    .incdec(incdec), .dec(dec), .rd_data(rd_data), .rd_valid(rd_valid),
    .hl_addr(hl_addr), .flag_z(flag_z), .flag_s(flag_s), .flag_p(flag_p),
    .flags_valid(flags_valid), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0] mreg [7];
  logic [7:0] rd_q [$];
  logic [2:0] fl_q [$];   // {z,s,p}
  logic [2:0] mflags;
  logic       exp_err;

  // Applies one cycle of stimulus, updates the model and queues the expected outputs.
  task automatic drive(input logic [6:0] rs, input logic [6:0] ws, input logic [7:0] wd,
                       input logic inc, input logic dc);
    int wi, ri;
    logic [7:0] nv;
    logic wmulti, rmulti;
    wi = -1; ri = -1;
    for (int i = 6; i >= 0; i--) begin
      if (ws[i]) wi = i;
      if (rs[i]) ri = i;
    end
    wmulti = $countones(ws) > 1;
    rmulti = $countones(rs) > 1;
`ifdef SP_SEL_CHECK_EN
    if (wmulti) wi = -1;
    if (rmulti) ri = -1;
    exp_err = wmulti | rmulti;
`else
    exp_err = 1'b0;
`endif
    nv = 8'h00;
    if (wi >= 0) nv = inc ? (dc ? mreg[wi] - 8'd1 : mreg[wi] + 8'd1) : wd;
    if (ri >= 0) rd_q.push_back((ri == wi) ? nv : mreg[ri]);
    if (wi >= 0 && inc) begin
      mflags = {nv == 8'h00, nv[7], ~^nv};
      fl_q.push_back(mflags);
    end
    if (wi >= 0) mreg[wi] = nv;
    rd_sel = rs; wr_sel = ws; wr_data = wd; incdec = inc; dec = dc;
    @(posedge clk); #1;
    rd_sel = '0; wr_sel = '0; wr_data = '0; incdec = 1'b0; dec = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({rd_data, rd_valid, flag_z, flag_s, flag_p, flags_valid, sel_err} !== 13'h0 ||
        hl_addr !== 14'h0)
      $display("FAIL reset_state: rd_data=%h rd_valid=%b z/s/p=%b%b%b fv=%b err=%b hl=%h, want all 0",
               rd_data, rd_valid, flag_z, flag_s, flag_p, flags_valid, sel_err, hl_addr);
    else passed++;
  endtask

  task automatic test_load_read;
    logic [7:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(7'h0, 7'(1 << i), 8'((i + 1) * 8'h11), 1'b0, 1'b0);
      total++;
      if (rd_valid !== 1'b0 || flags_valid !== 1'b0)
        $display("FAIL load_no_pulse r%0d: rd_valid=%b flags_valid=%b, want 0 0", i, rd_valid, flags_valid);
      else passed++;
    end
    for (int i = 0; i < 7; i++) begin
      drive(7'(1 << i), 7'h0, 8'h00, 1'b0, 1'b0);
      total++;
      if (rd_valid !== 1'b1 || rd_q.size() == 0)
        $display("FAIL read_valid r%0d: rd_valid=%b, want 1", i, rd_valid);
      else begin
        e = rd_q.pop_front();
        if (rd_data !== e) $display("FAIL read_data r%0d: got %h want %h", i, rd_data, e);
        else passed++;
      end
    end
    @(posedge clk); #1;
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h77)
      $display("FAIL read_idle: rd_valid=%b rd_data=%h, want 0 77", rd_valid, rd_data);
    else passed++;
  endtask

  task automatic test_incdec;
    logic [2:0] e;
    // B = FF, then +1 wraps to 00
    drive(7'h0, 7'b0000010, 8'hFF, 1'b0, 1'b0);
    drive(7'h0, 7'b0000010, 8'h00, 1'b1, 1'b0);
    total++;
    if (flags_valid !== 1'b1 || fl_q.size() == 0)
      $display("FAIL inc_wrap_valid: flags_valid=%b, want 1", flags_valid);
    else begin
      e = fl_q.pop_front();
      if ({flag_z, flag_s, flag_p} !== e || e !== 3'b101)
        $display("FAIL inc_wrap_flags: zsp=%b%b%b want %b", flag_z, flag_s, flag_p, e);
      else passed++;
    end
    @(posedge clk); #1;
    total++;
    if (flags_valid !== 1'b0) $display("FAIL inc_pulse_once: flags_valid=%b, want 0", flags_valid);
    else passed++;
    // C = 00, then -1 wraps to FF
    drive(7'h0, 7'b0000100, 8'h00, 1'b0, 1'b0);
    drive(7'h0, 7'b0000100, 8'h00, 1'b1, 1'b1);
    total++;
    if (flags_valid !== 1'b1 || fl_q.size() == 0)
      $display("FAIL dec_wrap_valid: flags_valid=%b, want 1", flags_valid);
    else begin
      e = fl_q.pop_front();
      if ({flag_z, flag_s, flag_p} !== e || e !== 3'b011)
        $display("FAIL dec_wrap_flags: zsp=%b%b%b want %b", flag_z, flag_s, flag_p, e);
      else passed++;
    end
    drive(7'h0, 7'h0, 8'h00, 1'b1, 1'b0);
    total++;
    if (flags_valid !== 1'b0 || {flag_z, flag_s, flag_p} !== mflags)
      $display("FAIL incdec_nosel: fv=%b zsp=%b%b%b, want 0 %b", flags_valid, flag_z, flag_s, flag_p, mflags);
    else passed++;
    // D = 41 (two ones), +1 -> 42, odd-free check of parity and non-zero path; read back B, C, D
    drive(7'h0, 7'b0001000, 8'h41, 1'b0, 1'b0);
    drive(7'b0001000, 7'b0001000, 8'h00, 1'b1, 1'b0);
    total++;
    if (flags_valid !== 1'b1 || fl_q.size() == 0 || rd_q.size() == 0)
      $display("FAIL inc_bypass_valid: flags_valid=%b rd_valid=%b, want 1 1", flags_valid, rd_valid);
    else begin
      e = fl_q.pop_front();
      if ({flag_z, flag_s, flag_p} !== e || rd_data !== rd_q.pop_front() || rd_data !== 8'h42)
        $display("FAIL inc_bypass: rd=%h zsp=%b%b%b, want 42 %b", rd_data, flag_z, flag_s, flag_p, e);
      else passed++;
    end
    for (int i = 1; i < 3; i++) begin
      drive(7'(1 << i), 7'h0, 8'h00, 1'b0, 1'b0);
      total++;
      if (rd_valid !== 1'b1 || rd_q.size() == 0)
        $display("FAIL incdec_readback r%0d: rd_valid=%b, want 1", i, rd_valid);
      else if (rd_data !== rd_q[0]) begin
        $display("FAIL incdec_readback r%0d: got %h want %h", i, rd_data, rd_q[0]);
        void'(rd_q.pop_front());
      end else begin
        void'(rd_q.pop_front());
        passed++;
      end
    end
  endtask

  task automatic test_bypass_hl;
    logic [7:0] e;
    drive(7'b0001000, 7'b0001000, 8'h5A, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_q.size() == 0)
      $display("FAIL bypass_valid: rd_valid=%b, want 1", rd_valid);
    else begin
      e = rd_q.pop_front();
      if (rd_data !== e || e !== 8'h5A) $display("FAIL bypass_data: got %h want %h", rd_data, e);
      else passed++;
    end
    // read A while writing E: independent
    drive(7'b0000001, 7'b0010000, 8'hC3, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_q.size() == 0)
      $display("FAIL indep_valid: rd_valid=%b, want 1", rd_valid);
    else begin
      e = rd_q.pop_front();
      if (rd_data !== e) $display("FAIL indep_data: got %h want %h", rd_data, e);
      else passed++;
    end
    drive(7'h0, 7'b0100000, 8'h3F, 1'b0, 1'b0);
    drive(7'h0, 7'b1000000, 8'h80, 1'b0, 1'b0);
    total++;
    if (hl_addr !== {mreg[5][5:0], mreg[6]} || hl_addr !== 14'h3F80)
      $display("FAIL hl_addr: got %h want 3f80", hl_addr);
    else passed++;
    drive(7'h0, 7'b0100000, 8'hFF, 1'b0, 1'b0);
    total++;
    if (hl_addr !== {mreg[5][5:0], mreg[6]})
      $display("FAIL hl_addr_h76: got %h want %h", hl_addr, {mreg[5][5:0], mreg[6]});
    else passed++;
    drive(7'h0, 7'b1000000, 8'h01, 1'b0, 1'b0);
    total++;
    if (hl_addr !== {mreg[5][5:0], mreg[6]})
      $display("FAIL hl_addr_l: got %h want %h", hl_addr, {mreg[5][5:0], mreg[6]});
    else passed++;
  endtask

  task automatic test_multihot;
    logic [7:0] e;
    drive(7'h0, 7'b0000011, 8'hAA, 1'b0, 1'b0);
    total++;
    if (sel_err !== exp_err) $display("FAIL multi_wr_err: sel_err=%b want %b", sel_err, exp_err);
    else passed++;
    drive(7'b0000110, 7'h0, 8'h00, 1'b0, 1'b0);
    total++;
    if (sel_err !== exp_err) $display("FAIL multi_rd_err: sel_err=%b want %b", sel_err, exp_err);
    else passed++;
`ifdef SP_SEL_CHECK_EN
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00)
      $display("FAIL multi_rd: rd_valid=%b rd_data=%h, want 0 00", rd_valid, rd_data);
    else passed++;
`else
    total++;
    if (rd_valid !== 1'b1 || rd_q.size() == 0)
      $display("FAIL multi_rd_valid: rd_valid=%b, want 1", rd_valid);
    else begin
      e = rd_q.pop_front();
      if (rd_data !== e) $display("FAIL multi_rd_data: got %h want %h", rd_data, e);
      else passed++;
    end
`endif
    @(posedge clk); #1;
    total++;
    if (sel_err !== 1'b0) $display("FAIL sel_err_once: sel_err=%b want 0", sel_err);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      drive(7'(1 << i), 7'h0, 8'h00, 1'b0, 1'b0);
      total++;
      if (rd_valid !== 1'b1 || rd_q.size() == 0)
        $display("FAIL multi_wr_readback r%0d: rd_valid=%b, want 1", i, rd_valid);
      else begin
        e = rd_q.pop_front();
        if (rd_data !== e) $display("FAIL multi_wr_readback r%0d: got %h want %h", i, rd_data, e);
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] e;
    drive(7'h0, 7'b0000100, 8'h00, 1'b1, 1'b0);   // flags non-zero state
    void'(fl_q.pop_front());
    rd_sel = 7'b0000001;
    @(posedge clk);
    #3 rst_n = 1'b0;
    rd_sel = '0;
    #1;
    total++;
    if ({rd_data, rd_valid, flag_z, flag_s, flag_p, flags_valid, sel_err} !== 13'h0 ||
        hl_addr !== 14'h0)
      $display("FAIL async_reset: rd_data=%h rd_valid=%b zsp=%b%b%b fv=%b hl=%h, want all 0",
               rd_data, rd_valid, flag_z, flag_s, flag_p, flags_valid, hl_addr);
    else passed++;
    rd_q.delete(); fl_q.delete();
    for (int i = 0; i < 7; i++) mreg[i] = 8'h00;
    mflags = 3'b000;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      drive(7'(1 << i), 7'h0, 8'h00, 1'b0, 1'b0);
      total++;
      if (rd_valid !== 1'b1 || rd_q.size() == 0)
        $display("FAIL post_reset_read r%0d: rd_valid=%b, want 1", i, rd_valid);
      else begin
        e = rd_q.pop_front();
        if (rd_data !== e) $display("FAIL post_reset_read r%0d: got %h want %h", i, rd_data, e);
        else passed++;
      end
    end
    drive(7'b0010000, 7'b0010000, 8'h00, 1'b1, 1'b1);
    total++;
    if (rd_q.size() == 0 || fl_q.size() == 0 || rd_data !== rd_q[0] ||
        {flag_z, flag_s, flag_p} !== fl_q[0])
      $display("FAIL post_reset_dec: rd=%h zsp=%b%b%b, want ff 011", rd_data, flag_z, flag_s, flag_p);
    else passed++;
    rd_q.delete(); fl_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; rd_sel = '0; wr_sel = '0; wr_data = '0; incdec = 1'b0; dec = 1'b0;
    mflags = 3'b000; exp_err = 1'b0;
    for (int i = 0; i < 7; i++) mreg[i] = 8'h00;
    #12;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_load_read;
    test_incdec;
    test_bypass_hl;
    test_multihot;
    test_async_reset;
    total++;
    if (rd_q.size() != 0 || fl_q.size() != 0)
      $display("FAIL scoreboard_drain: rd_q=%0d fl_q=%0d left, want 0 0", rd_q.size(), fl_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
